mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares the single mem_bus request port between the CPU instruction-fetch
//   port and the load/store data port. Round-robin arbitration, holds
//   bus_start for the full mem_bus handshake, returns one-cycle done pulses,
//   rejects data writes to flash and aborts hung transactions via a watchdog.
// PARAMETERS
//   ADDR_W      18    bus address width; [ADDR_W-1]=1 IO, [ADDR_W-2]=1 RAM, else flash
//   TIMEOUT     4095  max cycles bus_start held before abort (must fit TO_W)
//   TO_W        12    watchdog counter width
// PORTS
//   clk        in   1       clock
//   rst        in   1       synchronous reset, active-high
//   if_req     in   1       fetch request, level; addr stable while high
//   if_addr    in   ADDR_W  fetch address (always 4-byte read)
//   if_rdata   out  32      fetched word, valid with if_done
//   if_done    out  1       one-cycle completion pulse
//   if_err     out  1       with if_done: watchdog abort
//   d_req      in   1       data request, level; fields stable while high
//   d_addr     in   ADDR_W  data address
//   d_we       in   1       1 = write
//   d_wdata    in   32      write data
//   d_bytes    in   3       byte count 1/2/4
//   d_rdata    out  32      read data, valid with d_done
//   d_done     out  1       one-cycle completion pulse
//   d_err      out  1       with d_done: flash-write reject or watchdog abort
//   bus_start  out  1       to mem_bus start_request
//   bus_addr   out  ADDR_W  to mem_bus target_address (registered)
//   bus_we     out  1       to mem_bus is_write
//   bus_wdata  out  32      to mem_bus write_value
//   bus_bytes  out  3       to mem_bus num_bytes
//   bus_rdata  in   32      from mem_bus fetched_value
//   bus_done   in   1       from mem_bus request_done (level, held while start high)
//   owner      out  2       01 fetch, 10 data, 00 none
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, last_grant=data (so fetch wins first tie).
//   States: IDLE -> ISSUE -> RELEASE -> IDLE; IDLE -> REJECT -> IDLE.
//   IDLE: sample reqs. One pending -> grant it; both -> grant the one not in
//     last_grant. Latch addr/we/wdata/bytes into bus_* regs (fetch: we=0,
//     bytes=4), set owner, update last_grant, go ISSUE. Req seen cycle N ->
//     bus_start=1 cycle N+1.
//   Data write with d_addr[ADDR_W-1:ADDR_W-2]==2'b00 (flash): no bus access;
//     go REJECT; d_done=d_err=1 for one cycle at N+1; back to IDLE.
//   ISSUE: bus_start=1, watchdog counts up from 0. On bus_done=1: capture
//     bus_rdata into granted *_rdata, pulse granted *_done (err=0), drop
//     bus_start same edge, go RELEASE. If count reaches TIMEOUT first: drop
//     bus_start, pulse *_done with *_err=1, rdata=0, go RELEASE.
//   RELEASE: bus_start=0; wait bus_done==0 (mem_bus resets its FSM), then
//     owner=00, IDLE. Min one cycle here, so back-to-back grants are >=3 cycles apart.
//   Requester must drop req on the edge it samples done=1; a req still high
//     in IDLE is a new request. Req dropped mid-ISSUE is ignored: transaction
//     completes, done still pulses.
//   bus_* fields never change while bus_start=1. Never two done pulses same cycle.
//   Reset mid-ISSUE: bus_start low after that edge, no done pulse issued.
// STRUCTURE
//   Shared header mem_map.vh: region-select bit positions, region codes
//     (FLASH=2'b00, RAM=2'b01, IO=2'b1x), state encodings (one-hot, 4 bits).
//   Sub-module mem_arb_watchdog: TO_W counter, clear/enable in, expired out.
//   Arbiter FSM and datapath regs in mem_arbiter.
// TESTING
//   Fetch only, addr 18'h00100, bus_done after 40 cycles with 32'hDEADBEEF ->
//     bus_start high cycle 1..40, if_done pulse once, if_rdata=DEADBEEF, owner 01.
//   if_req and d_req same cycle after reset -> fetch granted first, data
//     second; next simultaneous pair -> data first (alternation over 4 pairs).
//   Data write d_addr=18'h00010 (flash) -> no bus_start, d_done=d_err=1 at N+1;
//     same to 18'h10010 (RAM) -> bus_we=1, bus_bytes as given, d_err=0.
//   bus_done never asserted, TIMEOUT=15 -> bus_start drops after 15 cycles,
//     d_done=d_err=1, d_rdata=0; following request served normally.
//   bus_done held high 3 cycles after start drop -> arbiter stays in RELEASE,
//     no new bus_start until bus_done=0.
//   rst=1 in mid-ISSUE -> next cycle bus_start=0, owner=00, no done pulse.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter: address regions, FSM state
// encoding, owner codes and the fixed fetch transfer size.
package mem_arbiter_pkg;

  // Region is selected by the two top address bits: 00 flash, 01 RAM, 1x IO.
  typedef enum logic [1:0] {
    RegionFlash = 2'b00,
    RegionRam   = 2'b01,
    RegionIoLo  = 2'b10,
    RegionIoHi  = 2'b11
  } region_e;

  // One-hot arbiter states.
  typedef enum logic [3:0] {
    StIdle    = 4'b0001,
    StIssue   = 4'b0010,
    StRelease = 4'b0100,
    StReject  = 4'b1000
  } arb_state_e;

  localparam logic [1:0] OwnerNone  = 2'b00;
  localparam logic [1:0] OwnerFetch = 2'b01;
  localparam logic [1:0] OwnerData  = 2'b10;

  // Instruction fetches are always full-word reads.
  localparam logic [2:0] FetchBytes = 3'd4;

  function automatic logic is_flash(input logic [1:0] region_bits);
    return region_e'(region_bits) == RegionFlash;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Watchdog for the arbiter's ISSUE phase: counts enabled cycles from zero and
// flags expiry on the TIMEOUT-th enabled cycle, so bus_start is held for at
// most TIMEOUT cycles before the arbiter aborts the transaction.
module mem_arb_watchdog #(
  parameter int unsigned TO_W    = 12,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] Limit = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count_q;

  // Count enabled cycles; saturate at the limit so a late abort cannot wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Expiry is seen while the limit-th enabled cycle is in progress.
  always_comb begin
    expired = enable && (count_q == Limit);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the mem_bus request port between the
// instruction-fetch port and the load/store data port. All bus-side and
// requester-side outputs are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned TIMEOUT = 4095,
  parameter int unsigned TO_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  output logic              if_err,
  // Load/store data port
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_bytes,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              d_err,
  // mem_bus side
  output logic              bus_start,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [31:0]       bus_wdata,
  output logic [2:0]        bus_bytes,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_done,
  output logic [1:0]        owner
);

  arb_state_e state_q, state_d;

  // 1 when the most recent grant went to the data port.
  logic last_data_q;

  logic grant_fetch;
  logic grant_data;
  logic data_reject;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  mem_arb_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Grant decision: a lone request wins; on a tie the port not granted last wins.
  always_comb begin
    grant_fetch = if_req && (!d_req || last_data_q);
    grant_data  = d_req && (!if_req || !last_data_q);
    data_reject = grant_data && d_we && is_flash(d_addr[ADDR_W-1:ADDR_W-2]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (data_reject) begin
          state_d = StReject;
        end else if (grant_fetch || grant_data) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus_done || wd_expired) begin
          state_d = StRelease;
        end
      end
      // Wait for mem_bus to drop its done level before the next grant.
      StRelease: begin
        if (!bus_done) begin
          state_d = StIdle;
        end
      end
      StReject: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State-decoded watchdog control.
  always_comb begin
    wd_clear  = 1'b1;
    wd_enable = 1'b0;
    if (state_q == StIssue) begin
      wd_clear  = 1'b0;
      wd_enable = 1'b1;
    end
  end

  // Registered datapath: bus fields, owner, done pulses and captured read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_data_q <= 1'b1;
      bus_start   <= 1'b0;
      bus_addr    <= '0;
      bus_we      <= 1'b0;
      bus_wdata   <= '0;
      bus_bytes   <= '0;
      owner       <= OwnerNone;
      if_rdata    <= '0;
      if_done     <= 1'b0;
      if_err      <= 1'b0;
      d_rdata     <= '0;
      d_done      <= 1'b0;
      d_err       <= 1'b0;
    end else begin
      // Done and error are single-cycle pulses.
      if_done <= 1'b0;
      if_err  <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_fetch) begin
            last_data_q <= 1'b0;
            bus_start   <= 1'b1;
            bus_addr    <= if_addr;
            bus_we      <= 1'b0;
            bus_wdata   <= '0;
            bus_bytes   <= FetchBytes;
            owner       <= OwnerFetch;
          end else if (grant_data) begin
            last_data_q <= 1'b1;
            if (data_reject) begin
              // Flash is read-only from the data port: answer without a bus access.
              d_done <= 1'b1;
              d_err  <= 1'b1;
            end else begin
              bus_start <= 1'b1;
              bus_addr  <= d_addr;
              bus_we    <= d_we;
              bus_wdata <= d_wdata;
              bus_bytes <= d_bytes;
              owner     <= OwnerData;
            end
          end
        end
        StIssue: begin
          // A completion on the expiry cycle still counts as a success.
          if (bus_done) begin
            bus_start <= 1'b0;
            if (owner == OwnerFetch) begin
              if_done  <= 1'b1;
              if_rdata <= bus_rdata;
            end else begin
              d_done  <= 1'b1;
              d_rdata <= bus_rdata;
            end
          end else if (wd_expired) begin
            bus_start <= 1'b0;
            if (owner == OwnerFetch) begin
              if_done  <= 1'b1;
              if_err   <= 1'b1;
              if_rdata <= '0;
            end else begin
              d_done  <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end
          end
        end
        StRelease: begin
          if (!bus_done) begin
            owner <= OwnerNone;
          end
        end
        StReject: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
